// File: rtl/ir_hit_decoder.sv
// ----------------------------------------------------------------------------
// ir_hit_decoder
//
// Turns the raw, active-low IR receiver line on the tank into validated hit
// events. The line is first synchronized into the PCLK domain, then
// deglitched by a stability filter. A small FSM measures each filtered low
// pulse. Only widths inside the accept window produce a hit. A hit is
// followed by a lockout period. A low that never ends is flagged as a stuck
// receiver.
//
// Ports:
//   PCLK        in   system clock, everything runs on its rising edge
//   PRESERN     in   synchronous active-low reset
//   hit_data    in   raw IR receiver output (asynchronous, low = carrier)
//   clr         in   one-cycle clear of hit_count and stuck_fault
//   hit_int     out  one-cycle pulse per accepted hit
//   hit_count   out  accepted hits, saturating at 15
//   stuck_fault out  sticky flag, set when a low lasts MAX_HIT_CYC cycles
//   busy        out  high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module ir_hit_decoder #(
    parameter int unsigned GLITCH_CYC   = 1000,
    parameter int unsigned MIN_HIT_CYC  = 10000000,
    parameter int unsigned MAX_HIT_CYC  = 50000000,
    parameter int unsigned COOLDOWN_CYC = 100000000
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       hit_data,
    input  logic       clr,
    output logic       hit_int,
    output logic [3:0] hit_count,
    output logic       stuck_fault,
    output logic       busy
);

    localparam logic [31:0] GLITCH_LAST = 32'(GLITCH_CYC - 1);
    localparam logic [31:0] MIN_W       = 32'(MIN_HIT_CYC);
    localparam logic [31:0] MAX_LAST    = 32'(MAX_HIT_CYC - 1);
    localparam logic [31:0] COOL_W      = 32'(COOLDOWN_CYC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOW      = 2'd1,
        STUCK    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    logic        sync_a;
    logic        sync_b;
    logic        filt;
    logic [31:0] stab;
    logic [1:0]  settle;
    logic        armed;

    state_t      state;
    state_t      state_next;
    logic [31:0] w;
    logic [31:0] w_next;

    logic        accept;
    logic        stuck_enter;
    logic        busy_next;

    // Two-flop synchronizer for the asynchronous receiver line. Both flops
    // come out of reset high, i.e. "no carrier".
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= hit_data;
            sync_b <= sync_a;
        end
    end

    // Stability filter: the filtered level follows the synchronized line
    // only after the new level has been seen on GLITCH_CYC consecutive
    // samples. Any return to the current filtered level restarts the count,
    // so short glitches are dropped while clean pulses keep their width
    // (both edges are delayed by the same amount).
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            filt <= 1'b1;
            stab <= 32'd0;
        end else if (sync_b == filt) begin
            stab <= 32'd0;
        end else if (stab == GLITCH_LAST) begin
            filt <= sync_b;
            stab <= 32'd0;
        end else begin
            stab <= stab + 32'd1;
        end
    end

    // Arming after reset. The synchronizer and the filter come out of reset
    // pretending the line is high, so a pulse that was already in progress
    // across reset would otherwise look like a fresh low once it propagated
    // through the filter. The decoder only starts measuring after it has
    // seen a genuinely sampled high on both the synchronized and the
    // filtered line. settle marks when sync_b holds a real sample rather
    // than its reset value.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && sync_b && filt) begin
                armed <= 1'b1;
            end
        end
    end

    // FSM state register together with the shared width / cooldown counter.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state <= IDLE;
            w     <= 32'd0;
        end else begin
            state <= state_next;
            w     <= w_next;
        end
    end

    // Next-state logic. In LOW, w holds the number of filtered-low samples
    // seen so far, counting the one that caused the exit from IDLE. Reaching
    // MAX_HIT_CYC low samples therefore happens on the edge where w moves
    // from MAX_HIT_CYC-1 with the line still low, which is where STUCK is
    // entered. A high seen with w at MAX_HIT_CYC-1 is still a valid hit.
    // In COOLDOWN the counter saturates at COOLDOWN_CYC so a receiver that
    // stays low for a long time cannot wrap it.
    always_comb begin
        state_next = state;
        w_next     = w;
        unique case (state)
            IDLE: begin
                w_next = 32'd0;
                if (armed && !filt) begin
                    state_next = LOW;
                    w_next     = 32'd1;
                end
            end
            LOW: begin
                if (!filt) begin
                    if (w >= MAX_LAST) begin
                        state_next = STUCK;
                        w_next     = 32'd0;
                    end else begin
                        w_next = w + 32'd1;
                    end
                end else begin
                    w_next = 32'd0;
                    if (w >= MIN_W) begin
                        state_next = COOLDOWN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            STUCK: begin
                w_next = 32'd0;
                if (filt) begin
                    state_next = IDLE;
                end
            end
            COOLDOWN: begin
                if (w < COOL_W) begin
                    w_next = w + 32'd1;
                end
                if ((w >= COOL_W) && filt) begin
                    state_next = IDLE;
                    w_next     = 32'd0;
                end
            end
            default: begin
                state_next = IDLE;
                w_next     = 32'd0;
            end
        endcase
    end

    // Output decode: the accept and stuck-entry events are the same
    // conditions that steer the FSM out of LOW. busy is computed from the
    // next state so the registered flag tracks the state register exactly.
    always_comb begin
        accept      = 1'b0;
        stuck_enter = 1'b0;
        busy_next   = (state_next != IDLE);
        if (state == LOW) begin
            accept      = filt && (w >= MIN_W);
            stuck_enter = !filt && (w >= MAX_LAST);
        end
    end

    // Registered outputs. A software clear takes priority over a hit or a
    // stuck detection landing in the same cycle. The hit pulse itself is not
    // affected by the clear, so software still sees the interrupt.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            hit_int     <= 1'b0;
            hit_count   <= 4'd0;
            stuck_fault <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hit_int <= accept;
            busy    <= busy_next;

            if (clr) begin
                hit_count <= 4'd0;
            end else if (accept && (hit_count != 4'd15)) begin
                hit_count <= hit_count + 4'd1;
            end

            if (clr) begin
                stuck_fault <= 1'b0;
            end else if (stuck_enter) begin
                stuck_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_hit_decoder.sv
// ----------------------------------------------------------------------------
// tb_ir_hit_decoder
//
// Self-checking bench for ir_hit_decoder with small timing parameters.
// Every pulse that should be accepted pushes its expected hit cycle and
// expected hit_count onto a queue. A monitor pops an entry on every hit_int
// and compares it. Each scenario task also checks its own end state.
// ----------------------------------------------------------------------------
module tb_ir_hit_decoder;

    localparam int G    = 4;
    localparam int MIN  = 20;
    localparam int MAX  = 100;
    localparam int COOL = 50;
    // Cycles from the last low sample of the raw line to the hit_int edge:
    // 2 synchronizer cycles + G filter cycles + 1 FSM sample.
    localparam int LAT  = 3 + G;

    logic       PCLK = 1'b0;
    logic       PRESERN;
    logic       hit_data;
    logic       clr;
    logic       hit_int;
    logic [3:0] hit_count;
    logic       stuck_fault;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] model_count = 4'd0;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
    } hit_exp_t;

    hit_exp_t exp_q[$];

    ir_hit_decoder #(
        .GLITCH_CYC  (G),
        .MIN_HIT_CYC (MIN),
        .MAX_HIT_CYC (MAX),
        .COOLDOWN_CYC(COOL)
    ) dut (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .hit_data   (hit_data),
        .clr        (clr),
        .hit_int    (hit_int),
        .hit_count  (hit_count),
        .stuck_fault(stuck_fault),
        .busy       (busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Scoreboard monitor: every hit pulse must match the oldest pending
    // expectation in both timing and count value.
    always @(negedge PCLK) begin
        if (hit_int === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_hit: hit_int=1 at cycle %0d, expected no hit", cyc);
            end else begin
                hit_exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("[TB] FAIL hit_timing: hit at cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
                checks++;
                if (hit_count !== e.cnt) begin
                    errors++;
                    $display("[TB] FAIL hit_count_at_hit: got %0d expected %0d", hit_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge PCLK);
        #1 clr = 1'b1;
        @(posedge PCLK);
        #1 clr = 1'b0;
        model_count = 4'd0;
    endtask

    // Drive a raw low of n cycles. When a hit is expected, the expectation
    // is queued before the hit can arrive. With clr_accept set, clr is
    // raised exactly in the accept cycle of that hit.
    task automatic pulse(input int n, input bit exp_hit, input bit clr_accept);
        int       k;
        hit_exp_t e;
        @(posedge PCLK);
        #1 hit_data = 1'b0;
        k = cyc;
        repeat (n) @(posedge PCLK);
        #1 hit_data = 1'b1;
        if (exp_hit) begin
            if (clr_accept) model_count = 4'd0;
            else if (model_count != 4'd15) model_count = model_count + 4'd1;
            e.cyc = k + n + LAT;
            e.cnt = model_count;
            exp_q.push_back(e);
        end
        if (clr_accept) begin
            repeat (LAT - 1) @(posedge PCLK);
            #1 clr = 1'b1;
            @(posedge PCLK);
            #1 clr = 1'b0;
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing_hits: %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_count(input string name);
        @(negedge PCLK);
        checks++;
        if (hit_count !== model_count) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d expected %0d", name, hit_count, model_count);
        end
    endtask

    task automatic wait_not_busy(input string name, input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge PCLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_busy_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        PRESERN  = 1'b0;
        hit_data = 1'b1;
        clr      = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({hit_int, hit_count, stuck_fault, busy} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                     {hit_int, hit_count, stuck_fault, busy});
        end
        @(posedge PCLK);
        #1 PRESERN = 1'b1;
        idle(5);
    endtask

    task automatic test_glitch();
        int bad_filt = 0;
        int bad_busy = 0;
        @(posedge PCLK);
        #1 hit_data = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge PCLK);
            #1;
            if (i == 2) hit_data = 1'b1;
            @(negedge PCLK);
            if (dut.filt !== 1'b1) bad_filt++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_filt != 0) begin
            errors++;
            $display("[TB] FAIL glitch_filt: filt changed in %0d samples, expected 0", bad_filt);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("[TB] FAIL glitch_busy: busy high in %0d samples, expected 0", bad_busy);
        end
        check_queue_empty("glitch");
    endtask

    task automatic test_width_window();
        pulse(MIN - 1, 1'b0, 1'b0);
        idle(200);
        pulse(MIN, 1'b1, 1'b0);
        idle(200);
        pulse(MAX - 1, 1'b1, 1'b0);
        idle(200);
        check_queue_empty("width");
        check_count("width");
        checks++;
        if (hit_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL width_end_count: got %0d expected 2", hit_count);
        end
    endtask

    task automatic test_stuck();
        @(posedge PCLK);
        #1 hit_data = 1'b0;
        repeat (G + 101) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if (stuck_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_early: got %b expected 0", stuck_fault);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if (stuck_fault !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stuck_set: got %b expected 1", stuck_fault);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stuck_busy: got %b expected 1", busy);
        end
        repeat (150 - (G + 102)) @(posedge PCLK);
        #1 hit_data = 1'b1;
        wait_not_busy("stuck", 40);
        checks++;
        if (stuck_fault !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stuck_sticky: got %b expected 1", stuck_fault);
        end
        pulse_clr();
        @(negedge PCLK);
        checks++;
        if (stuck_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_clr: got %b expected 0", stuck_fault);
        end
        check_count("stuck");
        check_queue_empty("stuck");
    endtask

    task automatic test_cooldown();
        int k;
        hit_exp_t e;
        // First pulse written out to also check when busy rises.
        @(posedge PCLK);
        #1 hit_data = 1'b0;
        k = cyc;
        repeat (G + 2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_rise_early: got %b expected 0", busy);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_rise: got %b expected 1", busy);
        end
        repeat (30 - (G + 3)) @(posedge PCLK);
        #1 hit_data = 1'b1;
        model_count = model_count + 4'd1;
        e.cyc = k + 30 + LAT;
        e.cnt = model_count;
        exp_q.push_back(e);
        idle(10);
        pulse(30, 1'b0, 1'b0);
        wait_not_busy("cooldown", 200);
        pulse(30, 1'b1, 1'b0);
        idle(80);
        check_queue_empty("cooldown");
        check_count("cooldown");
        checks++;
        if (hit_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL cooldown_end_count: got %0d expected 2", hit_count);
        end
    endtask

    task automatic test_saturation_clear();
        pulse_clr();
        for (int i = 0; i < 17; i++) begin
            pulse(25, 1'b1, 1'b0);
            idle(80);
        end
        check_count("saturate");
        checks++;
        if (hit_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturate_value: got %0d expected 15", hit_count);
        end
        pulse(25, 1'b1, 1'b1);
        idle(80);
        check_queue_empty("saturate");
        check_count("clr_accept");
    endtask

    task automatic test_reset_mid_low();
        @(posedge PCLK);
        #1 hit_data = 1'b0;
        // w reaches 10 on the edge G+12 cycles after the raw line falls.
        repeat (G + 12) @(posedge PCLK);
        #1 PRESERN = 1'b0;
        @(posedge PCLK);
        #1 PRESERN = 1'b1;
        model_count = 4'd0;
        @(negedge PCLK);
        checks++;
        if ({hit_int, hit_count, stuck_fault, busy} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %b expected 0000000",
                     {hit_int, hit_count, stuck_fault, busy});
        end
        repeat (40 - (G + 13)) @(posedge PCLK);
        #1 hit_data = 1'b1;
        idle(100);
        check_queue_empty("midreset_tail");
        check_count("midreset_tail");
        pulse(30, 1'b1, 1'b0);
        idle(80);
        check_queue_empty("midreset");
        check_count("midreset");
        checks++;
        if (hit_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL midreset_end_count: got %0d expected 1", hit_count);
        end
    endtask

    initial begin
        $display("[TB] starting ir_hit_decoder bench");
        test_reset();
        test_glitch();
        test_width_window();
        test_stuck();
        test_cooldown();
        test_saturation_clear();
        test_reset_mid_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
